// File: rtl/ps2_rx_frame_if.sv
// rtl/ps2_rx_frame_if.sv - receive-side result bundle of the PS/2 frame receiver
interface ps2_rx_frame_if;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_error;
   logic [1:0] rx_err_code;
   logic       busy;

   modport master (
      output rx_byte,
      output rx_valid,
      output rx_error,
      output rx_err_code,
      output busy
   );

   modport slave (
      input rx_byte,
      input rx_valid,
      input rx_error,
      input rx_err_code,
      input busy
   );
endinterface

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with deglitch, parity/stop checks and timeout
module ps2_rx_frame #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic           px_clk,
   input  logic           clr,
   input  logic           ps2_clk,
   input  logic           ps2_data,
   ps2_rx_frame_if.master rx
);
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   logic          clk_filt_q, clk_filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;

   state_t        state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [8:0]    shift_q, shift_d;
   logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_error_q, rx_error_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          busy_q, busy_d;

   // Deglitch: the filtered clock only follows the synced pin after
   // FILTER_LEN consecutive cycles of disagreement.
   always_comb begin
      clk_s1_d   = ps2_clk;
      clk_s2_d   = clk_s1_q;
      data_s1_d  = ps2_data;
      data_s2_d  = data_s1_q;
      clk_filt_d = clk_filt_q;
      filt_cnt_d = '0;
      if (clk_s2_q != clk_filt_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_filt_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
      fall = clk_filt_q & ~clk_filt_d;
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tcnt_d     = tcnt_q;
      tcnt_inc   = tcnt_q + 1'b1;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      rx_error_d = 1'b0;
      err_code_d = err_code_q;
      busy_d     = busy_q;

      unique case (state_q)
         S_IDLE: begin
            if (fall) begin
               if (!data_s2_q) begin
                  state_d   = S_RECV;
                  bit_cnt_d = 4'd1;
                  busy_d    = 1'b1;
                  tcnt_d    = '0;
               end else begin
                  rx_error_d = 1'b1;
                  err_code_d = 2'd1;
               end
            end
         end
         S_RECV: begin
            if (fall) begin
               tcnt_d    = '0;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd10) begin
                  // The verdict is registered here so the pulse shows during CHECK.
                  state_d = S_CHECK;
                  busy_d  = 1'b0;
                  if (!data_s2_q) begin
                     rx_error_d = 1'b1;
                     err_code_d = 2'd3;
                  end else if (!(^shift_q)) begin
                     rx_error_d = 1'b1;
                     err_code_d = 2'd2;
                  end else begin
                     rx_valid_d = 1'b1;
                     rx_byte_d  = shift_q[7:0];
                  end
               end else begin
                  shift_d = {data_s2_q, shift_q[8:1]};
               end
            end else if (tcnt_inc == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               tcnt_d     = '0;
               rx_error_d = 1'b1;
               err_code_d = 2'd0;
            end else begin
               tcnt_d = tcnt_inc;
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge px_clk) begin
      if (clr) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
         clk_filt_q <= 1'b1;
         filt_cnt_q <= '0;
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tcnt_q     <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_error_q <= 1'b0;
         err_code_q <= 2'd0;
         busy_q     <= 1'b0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         data_s1_q  <= data_s1_d;
         data_s2_q  <= data_s2_d;
         clk_filt_q <= clk_filt_d;
         filt_cnt_q <= filt_cnt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tcnt_q     <= tcnt_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_error_q <= rx_error_d;
         err_code_q <= err_code_d;
         busy_q     <= busy_d;
      end
   end

   assign rx.rx_byte     = rx_byte_q;
   assign rx.rx_valid    = rx_valid_q;
   assign rx.rx_error    = rx_error_q;
   assign rx.rx_err_code = err_code_q;
   assign rx.busy        = busy_q;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - randomized frame-level bench for ps2_rx_frame
module tb_ps2_rx_frame;
   localparam int FL = 8;
   localparam int TO = 300;
   localparam int HP = 40;

   logic px_clk = 1'b0;
   logic clr = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   ps2_rx_frame_if rx_if();

   ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .px_clk  (px_clk),
      .clr     (clr),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .rx      (rx_if)
   );

   always #5 px_clk = ~px_clk;

   int cyc = 0;
   always @(posedge px_clk) cyc = cyc + 1;

   int vectors = 0;
   int errors = 0;
   int last_fall_cyc = 0;
   logic [7:0] val_q[$];
   logic [1:0] err_q[$];
   int val_cyc = 0, err_cyc = 0, overlap = 0, stretched = 0;
   logic prev_v = 1'b0, prev_e = 1'b0;
   logic [7:0] last_good = 8'h00;

   always @(negedge px_clk) begin
      if (rx_if.rx_valid) begin val_q.push_back(rx_if.rx_byte); val_cyc = cyc; end
      if (rx_if.rx_error) begin err_q.push_back(rx_if.rx_err_code); err_cyc = cyc; end
      if (rx_if.rx_valid && rx_if.rx_error) overlap++;
      if ((rx_if.rx_valid && prev_v) || (rx_if.rx_error && prev_e)) stretched++;
      prev_v = rx_if.rx_valid;
      prev_e = rx_if.rx_error;
   end

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit stop);
      logic par;
      par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
      return {stop, par ^ bad_par, d, 1'b0};
   endfunction

   // Model outcome: -1 = good byte, otherwise the expected error code.
   function automatic int model_outcome(input logic [10:0] bits);
      if (bits[0]) return 1;
      if (!bits[10]) return 3;
      if ($countones(bits[9:1]) % 2 == 0) return 2;
      return -1;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge px_clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int from, input int upto);
      for (int i = from; i <= upto; i++) begin
         ps2_data = bits[i];
         idle(HP);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         idle(HP);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [10:0] bits);
      val_q.delete();
      err_q.delete();
      send_bits(bits, 0, 10);
      ps2_data = 1'b1;
      idle(60);
   endtask

   task automatic test_reset;
      clr = 1'b1;
      idle(4);
      clr = 1'b0;
      idle(2);
      vectors++; if (rx_if.rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", rx_if.rx_byte); end
      vectors++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_if.rx_valid); end
      vectors++; if (rx_if.rx_error !== 1'b0) begin errors++; $display("FAIL reset_rx_error got %b want 0", rx_if.rx_error); end
      vectors++; if (rx_if.rx_err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d want 0", rx_if.rx_err_code); end
      vectors++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_if.busy); end
   endtask

   task automatic test_single;
      logic [10:0] f;
      f = make_frame(8'h1C, 0, 1);
      val_q.delete();
      err_q.delete();
      send_bits(f, 0, 0);
      vectors++; if (rx_if.busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid got %b want 1", rx_if.busy); end
      send_bits(f, 1, 10);
      ps2_data = 1'b1;
      idle(20);
      vectors++; if (val_q.size() != 1 || err_q.size() != 0) begin errors++; $display("FAIL single_count got v=%0d e=%0d want v=1 e=0", val_q.size(), err_q.size()); end
      vectors++; if (rx_if.rx_byte !== 8'h1C) begin errors++; $display("FAIL single_byte got %h want 1c", rx_if.rx_byte); end
      vectors++; if (val_cyc != last_fall_cyc + FL + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", val_cyc, last_fall_cyc + FL + 2); end
      vectors++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", rx_if.busy); end
      last_good = 8'h1C;
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp[3];
      logic [7:0] got[$];
      int nerr;
      exp = '{8'hE0, 8'hF0, 8'h75};
      nerr = 0;
      for (int k = 0; k < 3; k++) begin
         send_frame(make_frame(exp[k], 0, 1));
         nerr += err_q.size();
         foreach (val_q[j]) got.push_back(val_q[j]);
      end
      vectors++; if (got.size() != 3 || nerr != 0) begin errors++; $display("FAIL b2b_count got v=%0d e=%0d want v=3 e=0", got.size(), nerr); end
      for (int k = 0; k < 3; k++) begin
         vectors++; if (got.size() != 3 || got[k] !== exp[k]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", k, (got.size() > k) ? got[k] : 8'hxx, exp[k]); end
      end
      last_good = 8'h75;
   endtask

   task automatic test_parity_error;
      send_frame(make_frame(8'h1C, 1, 1));
      vectors++; if (err_q.size() != 1 || val_q.size() != 0) begin errors++; $display("FAIL parity_count got v=%0d e=%0d want v=0 e=1", val_q.size(), err_q.size()); end
      vectors++; if (rx_if.rx_err_code !== 2'd2) begin errors++; $display("FAIL parity_code got %0d want 2", rx_if.rx_err_code); end
      vectors++; if (rx_if.rx_byte !== last_good) begin errors++; $display("FAIL parity_byte_kept got %h want %h", rx_if.rx_byte, last_good); end
   endtask

   task automatic test_stop_error;
      send_frame(make_frame(8'h33, 0, 0));
      vectors++; if (err_q.size() != 1 || val_q.size() != 0) begin errors++; $display("FAIL stop_count got v=%0d e=%0d want v=0 e=1", val_q.size(), err_q.size()); end
      vectors++; if (rx_if.rx_err_code !== 2'd3) begin errors++; $display("FAIL stop_code got %0d want 3", rx_if.rx_err_code); end
      send_frame(make_frame(8'h29, 0, 1));
      vectors++; if (val_q.size() != 1 || err_q.size() != 0 || rx_if.rx_byte !== 8'h29) begin errors++; $display("FAIL stop_recover got byte %h v=%0d e=%0d want 29 v=1 e=0", rx_if.rx_byte, val_q.size(), err_q.size()); end
      last_good = 8'h29;
   endtask

   task automatic test_start_error;
      val_q.delete();
      err_q.delete();
      send_bits(11'h7FF, 0, 0);
      idle(20);
      vectors++; if (err_q.size() != 1 || rx_if.rx_err_code !== 2'd1) begin errors++; $display("FAIL start_code got e=%0d code %0d want e=1 code 1", err_q.size(), rx_if.rx_err_code); end
      vectors++; if (err_cyc != last_fall_cyc + FL + 2 || rx_if.busy !== 1'b0) begin errors++; $display("FAIL start_latency got %0d busy %b want %0d busy 0", err_cyc, rx_if.busy, last_fall_cyc + FL + 2); end
   endtask

   task automatic test_timeout;
      val_q.delete();
      err_q.delete();
      send_bits(make_frame(8'hA5, 0, 1), 0, 4);
      ps2_data = 1'b1;
      for (int i = 0; i < TO + 200 && err_q.size() == 0; i++) idle(1);
      idle(5);
      vectors++; if (err_q.size() != 1 || val_q.size() != 0) begin errors++; $display("FAIL timeout_count got v=%0d e=%0d want v=0 e=1", val_q.size(), err_q.size()); end
      vectors++; if (((err_q.size() > 0) ? err_q[0] : 2'bxx) !== 2'd0) begin errors++; $display("FAIL timeout_code got %0d want 0", rx_if.rx_err_code); end
      vectors++; if (err_cyc != last_fall_cyc + FL + 1 + TO) begin errors++; $display("FAIL timeout_latency got %0d want %0d", err_cyc, last_fall_cyc + FL + 1 + TO); end
      vectors++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", rx_if.busy); end
   endtask

   task automatic test_glitch_clr;
      val_q.delete();
      err_q.delete();
      for (int g = 0; g < 5; g++) begin
         ps2_clk = 1'b0;
         idle(3);
         ps2_clk = 1'b1;
         idle(20 + $urandom_range(0, 10));
      end
      send_bits(make_frame(8'h16, 0, 1), 0, 3);
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      ps2_data = 1'b1;
      idle(TO + 50);
      vectors++; if (val_q.size() != 0 || err_q.size() != 0) begin errors++; $display("FAIL glitch_pulses got v=%0d e=%0d want 0 0", val_q.size(), err_q.size()); end
      vectors++; if (rx_if.busy !== 1'b0 || rx_if.rx_byte !== 8'h00) begin errors++; $display("FAIL glitch_state got busy %b byte %h want 0 00", rx_if.busy, rx_if.rx_byte); end
      send_frame(make_frame(8'h16, 0, 1));
      vectors++; if (val_q.size() != 1 || err_q.size() != 0 || rx_if.rx_byte !== 8'h16) begin errors++; $display("FAIL glitch_recover got byte %h v=%0d e=%0d want 16 1 0", rx_if.rx_byte, val_q.size(), err_q.size()); end
      last_good = 8'h16;
   endtask

   task automatic test_random;
      logic [7:0] d;
      logic [10:0] f;
      int kind, outc;
      for (int n = 0; n < 8; n++) begin
         d = 8'($urandom);
         kind = $urandom_range(0, 2);
         f = make_frame(d, kind == 1, kind != 2);
         outc = model_outcome(f);
         send_frame(f);
         if (outc < 0) begin
            last_good = d;
            vectors++; if (val_q.size() != 1 || err_q.size() != 0 || rx_if.rx_byte !== d) begin errors++; $display("FAIL rand%0d_good got byte %h v=%0d e=%0d want %h 1 0", n, rx_if.rx_byte, val_q.size(), err_q.size(), d); end
         end else begin
            vectors++; if (err_q.size() != 1 || val_q.size() != 0 || rx_if.rx_err_code !== 2'(outc) || rx_if.rx_byte !== last_good) begin errors++; $display("FAIL rand%0d_err got code %0d byte %h e=%0d want code %0d byte %h", n, rx_if.rx_err_code, rx_if.rx_byte, err_q.size(), outc, last_good); end
         end
      end
   endtask

   task automatic test_pulse_shape;
      vectors++; if (overlap != 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", overlap); end
      vectors++; if (stretched != 0) begin errors++; $display("FAIL pulse_width got %0d want 0", stretched); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity_error();
      test_stop_error();
      test_start_error();
      test_timeout();
      test_glitch_clr();
      test_random();
      test_pulse_shape();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
